// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg
// Shared types and constants for the CPU memory-bus arbiter slice.
//   state_e     : arbiter FSM states
//   owner_t     : bus owner encoding (OWN_FETCH / OWN_EXEC)
//   *_DEFAULT   : default address / data widths
//   other_owner : returns the requester that is not the given owner
package cpu_bus_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef logic owner_t;

  localparam owner_t OWN_FETCH = 1'b0;
  localparam owner_t OWN_EXEC  = 1'b1;

  function automatic owner_t other_owner(input owner_t own);
    return (own == OWN_FETCH) ? OWN_EXEC : OWN_FETCH;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the last_grant register; last_grant only moves when the
// parent accepts the grant via i_update.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_req_fetch         : fetch request (already masked by the parent)
//   i_req_exec          : exec request
//   i_update            : parent took the grant this cycle
//   o_gnt_valid         : at least one requester present
//   o_gnt_owner         : winning requester
module rr_arb2
  import cpu_bus_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_req_fetch,
  input  logic   i_req_exec,
  input  logic   i_update,
  output logic   o_gnt_valid,
  output owner_t o_gnt_owner
);

  owner_t r_last_grant;

  // Grant selection: a lone requester wins, a tie goes to the non-last owner
  always_comb begin
    o_gnt_valid = i_req_fetch | i_req_exec;
    if (i_req_fetch && i_req_exec) begin
      o_gnt_owner = other_owner(r_last_grant);
    end else if (i_req_exec) begin
      o_gnt_owner = OWN_EXEC;
    end else begin
      o_gnt_owner = OWN_FETCH;
    end
  end

  // last_grant register; reset to EXEC so fetch wins the first tie
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= OWN_EXEC;
    end else if (i_update) begin
      r_last_grant <= o_gnt_owner;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Serialises fetch-stage reads and exec-stage reads/writes onto a single
// memory port. Arbitration happens only in IDLE; every transaction ends in
// a one-cycle DONE state, so back-to-back transactions have a bubble.
// All outputs are registered.
//   i_clk, i_rst                     : clock, synchronous active-high reset
//   i_f_req/i_f_addr                 : fetch read request
//   o_f_rdata/o_f_valid              : fetched byte and its one-cycle pulse
//   i_x_req/i_x_we/i_x_addr/i_x_wdata: exec access request
//   o_x_rdata/o_x_done               : exec read data and completion pulse
//   i_flush                          : cancels/masks fetch, never exec
//   o_mem_addr/o_mem_data_out/o_mem_we/i_mem_data_in : memory port
//   o_busy                           : high whenever state != IDLE
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  output logic [DATA_W-1:0] o_f_rdata,
  output logic              o_f_valid,
  input  logic              i_x_req,
  input  logic              i_x_we,
  input  logic [ADDR_W-1:0] i_x_addr,
  input  logic [DATA_W-1:0] i_x_wdata,
  output logic [DATA_W-1:0] o_x_rdata,
  output logic              o_x_done,
  input  logic              i_flush,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data_out,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_data_in,
  output logic              o_busy
);

  // RD_WAIT lasts RD_LATENCY+1 cycles: RD_LATENCY for the memory, plus the
  // capture edge itself, so the counter compares against RD_LATENCY.
  localparam logic [2:0] LAT_CNT = 3'(RD_LATENCY);

  state_e              r_state;
  state_e              w_state_nxt;
  owner_t              r_owner;
  logic [2:0]          r_cnt;
  logic                r_kill;
  logic                w_kill_nxt;

  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data_out;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_f_rdata;
  logic                r_f_valid;
  logic [DATA_W-1:0]   r_x_rdata;
  logic                r_x_done;
  logic                r_busy;

  logic [ADDR_W-1:0]   w_mem_addr_nxt;
  logic [DATA_W-1:0]   w_mem_data_out_nxt;
  logic                w_mem_we_nxt;
  logic [DATA_W-1:0]   w_f_rdata_nxt;
  logic                w_f_valid_nxt;
  logic [DATA_W-1:0]   w_x_rdata_nxt;
  logic                w_x_done_nxt;

  logic                w_f_req_eff;
  logic                w_gnt_valid;
  owner_t              w_gnt_owner;
  logic                w_grant_take;
  logic                w_rd_capture;
  logic                w_fetch_owns;

  // Flush masks fetch for the arbitration it coincides with
  assign w_f_req_eff  = i_f_req & ~i_flush;
  assign w_grant_take = (r_state == IDLE) & w_gnt_valid;
  assign w_rd_capture = (r_state == RD_WAIT) & (r_cnt == LAT_CNT);
  // Fetch owns the bus during its transaction and on its own grant edge
  assign w_fetch_owns = ((r_state != IDLE) & (r_owner == OWN_FETCH)) |
                        (w_grant_take & (w_gnt_owner == OWN_FETCH));

  rr_arb2 u_rr_arb2 (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_fetch (w_f_req_eff),
    .i_req_exec  (i_x_req),
    .i_update    (w_grant_take),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_owner (w_gnt_owner)
  );

  // State register plus owner, latency counter and kill flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_owner <= OWN_FETCH;
      r_cnt   <= 3'd0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
      if (w_grant_take) begin
        r_owner <= w_gnt_owner;
        r_cnt   <= 3'd0;
      end else if (r_state == RD_WAIT) begin
        r_owner <= r_owner;
        r_cnt   <= r_cnt + 3'd1;
      end else begin
        r_owner <= r_owner;
        r_cnt   <= r_cnt;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_take) begin
          if ((w_gnt_owner == OWN_EXEC) && i_x_we) begin
            w_state_nxt = WR;
          end else begin
            w_state_nxt = RD_WAIT;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (w_rd_capture) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RD_WAIT;
        end
      end
      WR:      w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Kill: set by flush while fetch owns the bus, cleared on return to IDLE
  always_comb begin
    if (w_state_nxt == IDLE) begin
      w_kill_nxt = 1'b0;
    end else if (i_flush && w_fetch_owns) begin
      w_kill_nxt = 1'b1;
    end else begin
      w_kill_nxt = r_kill;
    end
  end

  // Output logic: next values for the registered outputs
  always_comb begin
    w_mem_addr_nxt     = r_mem_addr;
    w_mem_data_out_nxt = r_mem_data_out;
    w_mem_we_nxt       = 1'b0;
    w_f_rdata_nxt      = r_f_rdata;
    w_f_valid_nxt      = 1'b0;
    w_x_rdata_nxt      = r_x_rdata;
    w_x_done_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_take) begin
          if (w_gnt_owner == OWN_EXEC) begin
            w_mem_addr_nxt = i_x_addr;
            if (i_x_we) begin
              w_mem_data_out_nxt = i_x_wdata;
              w_mem_we_nxt       = 1'b1;
            end else begin
              w_mem_data_out_nxt = r_mem_data_out;
            end
          end else begin
            w_mem_addr_nxt = i_f_addr;
          end
        end else begin
          w_mem_addr_nxt = r_mem_addr;
        end
      end
      RD_WAIT: begin
        if (w_rd_capture) begin
          if (r_owner == OWN_EXEC) begin
            w_x_rdata_nxt = i_mem_data_in;
            w_x_done_nxt  = 1'b1;
          end else if (!r_kill && !i_flush) begin
            // A flush on the capture edge itself also kills the fetch
            w_f_rdata_nxt = i_mem_data_in;
            w_f_valid_nxt = 1'b1;
          end else begin
            w_f_rdata_nxt = r_f_rdata;
          end
        end else begin
          w_f_valid_nxt = 1'b0;
        end
      end
      WR:      w_x_done_nxt = 1'b1;
      DONE:    w_mem_we_nxt = 1'b0;
      default: w_mem_we_nxt = 1'b0;
    endcase
  end

  // Output registers; reset also aborts any transaction in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem_addr     <= '0;
      r_mem_data_out <= '0;
      r_mem_we       <= 1'b0;
      r_f_rdata      <= '0;
      r_f_valid      <= 1'b0;
      r_x_rdata      <= '0;
      r_x_done       <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_mem_addr     <= w_mem_addr_nxt;
      r_mem_data_out <= w_mem_data_out_nxt;
      r_mem_we       <= w_mem_we_nxt;
      r_f_rdata      <= w_f_rdata_nxt;
      r_f_valid      <= w_f_valid_nxt;
      r_x_rdata      <= w_x_rdata_nxt;
      r_x_done       <= w_x_done_nxt;
      r_busy         <= (w_state_nxt != IDLE);
    end
  end

  assign o_mem_addr     = r_mem_addr;
  assign o_mem_data_out = r_mem_data_out;
  assign o_mem_we       = r_mem_we;
  assign o_f_rdata      = r_f_rdata;
  assign o_f_valid      = r_f_valid;
  assign o_x_rdata      = r_x_rdata;
  assign o_x_done       = r_x_done;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter with a 256-byte memory model that has
// one cycle of read latency. Memory is preloaded on reset with
// mem[a] = a ^ 0xB5, so mem[0x10]=0xA5, mem[0x05]=0xB0, mem[0x00]=0xB5.
module tb_mem_bus_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_f_req;
  logic [7:0] i_f_addr;
  logic [7:0] o_f_rdata;
  logic       o_f_valid;
  logic       i_x_req;
  logic       i_x_we;
  logic [7:0] i_x_addr;
  logic [7:0] i_x_wdata;
  logic [7:0] o_x_rdata;
  logic       o_x_done;
  logic       i_flush;
  logic [7:0] o_mem_addr;
  logic [7:0] o_mem_data_out;
  logic       o_mem_we;
  logic [7:0] mem_rdata;
  logic       o_busy;

  logic [7:0] mem [256];

  int n_total = 0;
  int n_bad   = 0;

  mem_bus_arbiter #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .RD_LATENCY (1)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_f_req        (i_f_req),
    .i_f_addr       (i_f_addr),
    .o_f_rdata      (o_f_rdata),
    .o_f_valid      (o_f_valid),
    .i_x_req        (i_x_req),
    .i_x_we         (i_x_we),
    .i_x_addr       (i_x_addr),
    .i_x_wdata      (i_x_wdata),
    .o_x_rdata      (o_x_rdata),
    .o_x_done       (o_x_done),
    .i_flush        (i_flush),
    .o_mem_addr     (o_mem_addr),
    .o_mem_data_out (o_mem_data_out),
    .o_mem_we       (o_mem_we),
    .i_mem_data_in  (mem_rdata),
    .o_busy         (o_busy)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Memory model: synchronous write, one-cycle registered read
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hB5;
      mem_rdata <= 8'h00;
    end else begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_data_out;
      mem_rdata <= mem[o_mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1; i_f_req = 1'b0; i_f_addr = 8'h00; i_x_req = 1'b0; i_x_we = 1'b0;
    i_x_addr = 8'h00; i_x_wdata = 8'h00; i_flush = 1'b0;
    tick(); tick();
    // Reset state
    check_val("rst_busy", o_busy, 0);
    check_val("rst_fvalid", o_f_valid, 0);
    check_val("rst_xdone", o_x_done, 0);
    check_val("rst_memwe", o_mem_we, 0);
    check_val("rst_memaddr", o_mem_addr, 0);

    // Both request from reset: fetch, exec, fetch alternation
    i_f_req = 1'b1; i_f_addr = 8'h10;
    i_x_req = 1'b1; i_x_we = 1'b0; i_x_addr = 8'h05;
    i_rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check_val($sformatf("alt_addr%0d", k), o_mem_addr, (k < 4 || k >= 8) ? 8'h10 : 8'h05);
      check_val($sformatf("alt_fv%0d", k), o_f_valid, (k == 2 || k == 10) ? 1 : 0);
      check_val($sformatf("alt_xd%0d", k), o_x_done, (k == 6) ? 1 : 0);
      if (k == 6) check_val("alt_xrdata", o_x_rdata, 8'hB0);
      if (k == 10) check_val("alt_frdata", o_f_rdata, 8'hA5);
    end
    i_f_req = 1'b0; i_x_req = 1'b0;
    tick();

    // Fetch only from 0x10
    i_f_req = 1'b1; i_f_addr = 8'h10;
    tick();
    check_val("f1_addr", o_mem_addr, 8'h10);
    check_val("f1_busy_a", o_busy, 1);
    check_val("f1_fv_a", o_f_valid, 0);
    tick();
    check_val("f1_busy_b", o_busy, 1);
    check_val("f1_fv_b", o_f_valid, 0);
    tick();
    check_val("f1_busy_c", o_busy, 1);
    check_val("f1_fvalid", o_f_valid, 1);
    check_val("f1_rdata", o_f_rdata, 8'hA5);
    i_f_req = 1'b0;
    tick();
    check_val("f1_idle", o_busy, 0);
    check_val("f1_fv_end", o_f_valid, 0);

    // Exec write 0x3C to 0x20
    i_x_req = 1'b1; i_x_we = 1'b1; i_x_addr = 8'h20; i_x_wdata = 8'h3C;
    tick();
    check_val("wr_we", o_mem_we, 1);
    check_val("wr_addr", o_mem_addr, 8'h20);
    check_val("wr_data", o_mem_data_out, 8'h3C);
    check_val("wr_xd_a", o_x_done, 0);
    tick();
    check_val("wr_we_off", o_mem_we, 0);
    check_val("wr_xdone", o_x_done, 1);
    i_x_req = 1'b0;
    tick();
    check_val("wr_xd_end", o_x_done, 0);
    check_val("wr_idle", o_busy, 0);

    // Exec readback of 0x20
    i_x_req = 1'b1; i_x_we = 1'b0; i_x_addr = 8'h20;
    tick();
    check_val("rb_we", o_mem_we, 0);
    tick();
    check_val("rb_xd_a", o_x_done, 0);
    tick();
    check_val("rb_xdone", o_x_done, 1);
    check_val("rb_data", o_x_rdata, 8'h3C);
    i_x_req = 1'b0;
    tick();

    // Fetch 0x05 killed by a one-cycle flush in RD_WAIT
    i_f_req = 1'b1; i_f_addr = 8'h05;
    tick();
    check_val("fl_busy", o_busy, 1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    tick();
    check_val("fl_nofv", o_f_valid, 0);
    check_val("fl_rdata_kept", o_f_rdata, 8'hA5);
    check_val("fl_done_busy", o_busy, 1);
    i_f_req = 1'b0;
    tick();
    check_val("fl_idle", o_busy, 0);
    check_val("fl_nofv2", o_f_valid, 0);
    // Next fetch to 0x00 served normally
    i_f_req = 1'b1; i_f_addr = 8'h00;
    tick(); tick(); tick();
    check_val("fl_next_fv", o_f_valid, 1);
    check_val("fl_next_rdata", o_f_rdata, 8'hB5);
    i_f_req = 1'b0;
    tick();

    // Flush held with both requesting: exec only until flush drops
    i_flush = 1'b1;
    i_f_req = 1'b1; i_f_addr = 8'h10;
    i_x_req = 1'b1; i_x_we = 1'b0; i_x_addr = 8'h05;
    tick();
    check_val("fh_addr", o_mem_addr, 8'h05);
    check_val("fh_busy", o_busy, 1);
    tick(); tick();
    check_val("fh_xdone", o_x_done, 1);
    check_val("fh_xrdata", o_x_rdata, 8'hB0);
    i_x_req = 1'b0;
    tick();
    check_val("fh_idle_a", o_busy, 0);
    tick();
    check_val("fh_masked_a", o_busy, 0);
    tick();
    check_val("fh_masked_b", o_busy, 0);
    check_val("fh_masked_fv", o_f_valid, 0);
    i_flush = 1'b0;
    tick();
    check_val("fh_fgrant", o_busy, 1);
    check_val("fh_faddr", o_mem_addr, 8'h10);
    tick(); tick();
    check_val("fh_fvalid", o_f_valid, 1);
    check_val("fh_frdata", o_f_rdata, 8'hA5);
    i_f_req = 1'b0;
    tick();

    // Reset during WR
    i_x_req = 1'b1; i_x_we = 1'b1; i_x_addr = 8'h30; i_x_wdata = 8'h5A;
    tick();
    check_val("rw_we_on", o_mem_we, 1);
    i_rst = 1'b1;
    tick();
    check_val("rw_we_off", o_mem_we, 0);
    check_val("rw_xdone", o_x_done, 0);
    check_val("rw_busy", o_busy, 0);
    check_val("rw_addr", o_mem_addr, 0);
    check_val("rw_dout", o_mem_data_out, 0);
    check_val("rw_frdata", o_f_rdata, 0);
    check_val("rw_xrdata", o_x_rdata, 0);
    i_x_req = 1'b0; i_rst = 1'b0;
    tick();
    check_val("rw_no_late_done", o_x_done, 0);
    check_val("rw_idle", o_busy, 0);
    // Post-reset tie: fetch wins again
    i_f_req = 1'b1; i_f_addr = 8'h10;
    i_x_req = 1'b1; i_x_we = 1'b0; i_x_addr = 8'h05;
    tick();
    check_val("rw_tie_fetch", o_mem_addr, 8'h10);
    i_f_req = 1'b0; i_x_req = 1'b0;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
